// File: rtl/cam_frame_capture.sv
// DVP byte stream to RGB565 frame-buffer writer, one frame per ignite_cam request.
// Optional CAM_GRAY_EN: output stage converts each pixel to 8-bit grayscale.
module cam_frame_capture #(
   parameter int IMG_W     = 320,
   parameter int IMG_H     = 240,
   parameter int ADDRWIDTH = 18
) (
   input  logic                 pclk,
   input  logic                 preset,
   input  logic                 ignite_cam,
   output logic                 ignite_cam_ready,
   input  logic                 write_addr_index,
   input  logic                 cam_vsync,
   input  logic                 cam_href,
   input  logic                 cam_pvalid,
   input  logic [7:0]           cam_data,
   output logic                 fb_wr_en,
   output logic [ADDRWIDTH-1:0] fb_wr_addr,
   output logic [15:0]          fb_wr_data,
   output logic                 frame_short
);
   localparam int FRAME_PIX = IMG_W * IMG_H;
   localparam logic [ADDRWIDTH-1:0] FRAME_PIX_A = ADDRWIDTH'(FRAME_PIX);

   typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DONE, RELEASE} state_t;

   state_t                 state_q, state_d;
   logic                   bank_q, bank_d;
   logic                   vsync_q, vsync_d;
   logic                   href_q, href_d;
   logic                   phase_q, phase_d;
   logic [7:0]             hi_q, hi_d;
   logic [15:0]            col_q, col_d;
   logic [15:0]            line_q, line_d;
   logic [ADDRWIDTH-1:0]   idx_q, idx_d;
   logic                   pix_vld_q, pix_vld_d;
   logic [15:0]            pix_q, pix_d;
   logic [ADDRWIDTH-1:0]   pix_addr_q, pix_addr_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDRWIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [15:0]            wr_data_q, wr_data_d;
   logic                   ready_q, ready_d;
   logic                   short_q, short_d;

   logic                   vs_rise, href_fall, byte_ok;
   logic [ADDRWIDTH-1:0]   base;

   function automatic logic [15:0] to_out(input logic [15:0] p);
`ifdef CAM_GRAY_EN
      logic [7:0]  r8, g8, b8;
      logic [15:0] sum;
      r8  = {p[15:11], p[15:13]};
      g8  = {p[10:5],  p[10:9]};
      b8  = {p[4:0],   p[4:2]};
      // Weights sum to 256, so the 16-bit sum cannot overflow.
      sum = 16'(r8) * 16'd77 + 16'(g8) * 16'd150 + 16'(b8) * 16'd29;
      return {8'h00, sum[15:8]};
`else
      return p;
`endif
   endfunction

   assign vs_rise   = cam_vsync & ~vsync_q;
   assign href_fall = href_q & ~cam_href;
   assign byte_ok   = cam_href & cam_pvalid;
   assign base      = bank_q ? FRAME_PIX_A : '0;

   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      vsync_d    = cam_vsync;
      href_d     = cam_href;
      phase_d    = phase_q;
      hi_d       = hi_q;
      col_d      = col_q;
      line_d     = line_q;
      idx_d      = idx_q;
      pix_vld_d  = 1'b0;
      pix_d      = pix_q;
      pix_addr_d = pix_addr_q;
      wr_en_d    = pix_vld_q;
      wr_addr_d  = pix_vld_q ? pix_addr_q : wr_addr_q;
      wr_data_d  = pix_vld_q ? to_out(pix_q) : wr_data_q;
      ready_d    = 1'b0;
      short_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (ignite_cam) begin
               bank_d  = write_addr_index;
               state_d = ARM;
            end
         end
         ARM: begin
            if (vs_rise) begin
               col_d   = '0;
               line_d  = '0;
               idx_d   = '0;
               phase_d = 1'b0;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            // Completion is checked first so it beats a coincident vsync edge.
            if (idx_q == FRAME_PIX_A) begin
               state_d = DONE;
            end else if (vs_rise) begin
               short_d = 1'b1;
               state_d = DONE;
            end else if (href_fall) begin
               col_d   = '0;
               phase_d = 1'b0;
               if (line_q < 16'(IMG_H)) line_d = line_q + 16'd1;
            end else if (byte_ok) begin
               if (!phase_q) begin
                  hi_d    = cam_data;
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (col_q < 16'(IMG_W)) begin
                     col_d = col_q + 16'd1;
                     if (line_q < 16'(IMG_H)) begin
                        pix_vld_d  = 1'b1;
                        pix_d      = {hi_q, cam_data};
                        pix_addr_d = base + idx_q;
                        idx_d      = idx_q + 1'b1;
                     end
                  end
               end
            end
         end
         DONE: begin
            ready_d = 1'b1;
            state_d = RELEASE;
         end
         RELEASE: begin
            if (!ignite_cam) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q    <= IDLE;
         bank_q     <= 1'b0;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         phase_q    <= 1'b0;
         hi_q       <= '0;
         col_q      <= '0;
         line_q     <= '0;
         idx_q      <= '0;
         pix_vld_q  <= 1'b0;
         pix_q      <= '0;
         pix_addr_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         ready_q    <= 1'b0;
         short_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         vsync_q    <= vsync_d;
         href_q     <= href_d;
         phase_q    <= phase_d;
         hi_q       <= hi_d;
         col_q      <= col_d;
         line_q     <= line_d;
         idx_q      <= idx_d;
         pix_vld_q  <= pix_vld_d;
         pix_q      <= pix_d;
         pix_addr_q <= pix_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         ready_q    <= ready_d;
         short_q    <= short_d;
      end
   end

   assign fb_wr_en         = wr_en_q;
   assign fb_wr_addr       = wr_addr_q;
   assign fb_wr_data       = wr_data_q;
   assign ignite_cam_ready = ready_q;
   assign frame_short      = short_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed-plus-random bench for cam_frame_capture on a 4x2 frame; expected writes
// come from a line/pixel model of the capture rules.
module tb_cam_frame_capture;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 18;
   localparam int FP = W * H;

   logic          pclk = 1'b0;
   logic          preset, ignite_cam, ignite_cam_ready, write_addr_index;
   logic          cam_vsync, cam_href, cam_pvalid;
   logic [7:0]    cam_data;
   logic          fb_wr_en, frame_short;
   logic [AW-1:0] fb_wr_addr;
   logic [15:0]   fb_wr_data;

   cam_frame_capture #(.IMG_W(W), .IMG_H(H), .ADDRWIDTH(AW)) dut (
      .pclk(pclk), .preset(preset), .ignite_cam(ignite_cam),
      .ignite_cam_ready(ignite_cam_ready), .write_addr_index(write_addr_index),
      .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pvalid(cam_pvalid),
      .cam_data(cam_data), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr),
      .fb_wr_data(fb_wr_data), .frame_short(frame_short)
   );

   always #5 pclk = ~pclk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int got_addr[$];
   int got_data[$];
   int got_cyc[$];
   int rdy_cnt = 0;
   int rdy_cyc = 0;
   int short_cnt = 0;
   int exp_addr[$];
   int exp_data[$];
   logic [7:0] lb[2][16];
   int ll[2];

   always @(posedge pclk) cyc <= cyc + 1;

   always @(negedge pclk) begin
      if (fb_wr_en) begin
         got_addr.push_back(int'(fb_wr_addr));
         got_data.push_back(int'(fb_wr_data));
         got_cyc.push_back(cyc);
      end
      if (ignite_cam_ready) begin
         rdy_cnt = rdy_cnt + 1;
         rdy_cyc = cyc;
      end
      if (frame_short) short_cnt = short_cnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic int ref_pix(input int hi, input int lo);
      int p;
      p = (hi << 8) | lo;
`ifdef CAM_GRAY_EN
      begin
         int r, g, b;
         r = (p >> 11) & 31;
         g = (p >> 5) & 63;
         b = p & 31;
         r = (r << 3) | (r >> 2);
         g = (g << 2) | (g >> 4);
         b = (b << 3) | (b >> 2);
         return ((77 * r + 150 * g + 29 * b) >> 8) & 255;
      end
`else
      return p;
`endif
   endfunction

   // Frame model: each line yields len/2 pixels, the first W kept, lines past H
   // ignored, writes stop at FP.
   task automatic build_exp(input int bank, input int nlines);
      int cnt;
      exp_addr.delete();
      exp_data.delete();
      cnt = 0;
      for (int l = 0; l < nlines; l++)
         if (l < H)
            for (int c = 0; c < ll[l] / 2; c++)
               if (c < W && cnt < FP) begin
                  exp_addr.push_back(bank * FP + cnt);
                  exp_data.push_back(ref_pix(int'(lb[l][2*c]), int'(lb[l][2*c+1])));
                  cnt++;
               end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic vsync_pulse();
      cam_vsync = 1'b1;
      tick(); tick();
      cam_vsync = 1'b0;
      tick();
   endtask

   task automatic send_line(input int l);
      cam_href = 1'b1;
      for (int i = 0; i < ll[l]; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            cam_pvalid = 1'b0;
            tick();
         end
         cam_pvalid = 1'b1;
         cam_data   = lb[l][i];
         tick();
      end
      cam_pvalid = 1'b0;
      cam_href   = 1'b0;
      tick(); tick();
   endtask

   task automatic rand_lines();
      for (int l = 0; l < 2; l++) begin
         ll[l] = 2 * W;
         for (int i = 0; i < 16; i++) lb[l][i] = 8'($urandom);
      end
   endtask

   // Leaves ignite_cam high so the caller can probe the RELEASE state.
   task automatic run_frame(input string tag, input int bank, input int nlines,
                            input bit toggle, input bit short_end);
      int n0, r0, s0, nw;
      n0 = got_addr.size();
      r0 = rdy_cnt;
      s0 = short_cnt;
      build_exp(bank, nlines);
      write_addr_index = bank[0];
      ignite_cam = 1'b1;
      tick(); tick(); tick();
      vsync_pulse();
      tick();
      for (int l = 0; l < nlines; l++) begin
         if (toggle && l == 1) write_addr_index = ~bank[0];
         send_line(l);
      end
      if (short_end) vsync_pulse();
      for (int k = 0; k < 40 && rdy_cnt == r0; k++) tick();
      tick(); tick();
      nw = got_addr.size() - n0;
      chk({tag, "_nwrites"}, nw, exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < nw; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), got_addr[n0+i], exp_addr[i]);
         chk($sformatf("%s_data%0d", tag, i), got_data[n0+i], exp_data[i]);
      end
      chk({tag, "_ready_cnt"}, rdy_cnt - r0, 1);
      chk({tag, "_short_cnt"}, short_cnt - s0, short_end ? 1 : 0);
      if (!short_end && nw > 0)
         chk({tag, "_ready_lat"}, rdy_cyc - got_cyc[got_cyc.size()-1], 1);
   endtask

   task automatic drop_ignite();
      ignite_cam = 1'b0;
      tick(); tick();
   endtask

   initial begin
      int n0, r0;
      preset = 1'b1; ignite_cam = 1'b0; write_addr_index = 1'b0;
      cam_vsync = 1'b0; cam_href = 1'b0; cam_pvalid = 1'b0; cam_data = 8'h00;
      tick(); tick();
      chk("rst_wr_en", int'(fb_wr_en), 0);
      chk("rst_ready", int'(ignite_cam_ready), 0);
      chk("rst_short", int'(frame_short), 0);
      chk("rst_addr", int'(fb_wr_addr), 0);
      chk("rst_data", int'(fb_wr_data), 0);
      preset = 1'b0;
      tick();

      // Basic bank-0 frame, then a stale request must not re-trigger.
      rand_lines();
      run_frame("bank0", 0, 2, 1'b0, 1'b0);
      n0 = got_addr.size();
      r0 = rdy_cnt;
      vsync_pulse();
      tick();
      send_line(0);
      tick(); tick(); tick();
      chk("release_no_wr", got_addr.size() - n0, 0);
      chk("release_no_rdy", rdy_cnt - r0, 0);
      drop_ignite();

      // Bank 1 with write_addr_index toggled mid-frame.
      rand_lines();
      run_frame("bank1", 1, 2, 1'b1, 1'b0);
      drop_ignite();

      // Extreme colour values through the output stage.
      rand_lines();
      lb[0][0] = 8'hFF; lb[0][1] = 8'hFF; lb[0][2] = 8'hF8; lb[0][3] = 8'h00;
      n0 = got_addr.size();
      run_frame("color", 0, 2, 1'b0, 1'b0);
`ifdef CAM_GRAY_EN
      chk("white_px", got_data[n0], 'h00FF);
      chk("red_px", got_data[n0+1], 'h004C);
`else
      chk("white_px", got_data[n0], 'hFFFF);
      chk("red_px", got_data[n0+1], 'hF800);
`endif
      drop_ignite();

      // Over-long line with an odd trailing byte.
      rand_lines();
      ll[0] = 11;
      run_frame("longline", 0, 2, 1'b0, 1'b0);
      drop_ignite();

      // Short frame: vsync after 5 pixels.
      rand_lines();
      ll[1] = 2;
      run_frame("short", 1, 2, 1'b0, 1'b1);
      drop_ignite();

      // Reset mid-line.
      rand_lines();
      ignite_cam = 1'b1;
      tick(); tick(); tick();
      vsync_pulse();
      tick();
      r0 = rdy_cnt;
      cam_href = 1'b1;
      cam_pvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cam_data = lb[0][i];
         tick();
      end
      preset = 1'b1;
      tick();
      n0 = got_addr.size();
      chk("rst_mid_wr_en", int'(fb_wr_en), 0);
      preset = 1'b0;
      cam_href = 1'b0;
      cam_pvalid = 1'b0;
      ignite_cam = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("rst_mid_no_wr", got_addr.size() - n0, 0);
      chk("rst_mid_no_rdy", rdy_cnt - r0, 0);

      rand_lines();
      run_frame("after_rst", 0, 2, 1'b0, 1'b0);
      drop_ignite();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
